count_sequencer: RTL

Controller for the lab counter datapath. It sequences an up-counter through start/pause/clear/terminal-count phases and paces it with an internal prescaler tick. It reports busy, a one-cycle done pulse and its FSM state, and it is the block a top level wires to keys/switches and HEX/LED displays.

---
 rtl/count_sequencer_pkg.sv | 16 +
 rtl/rate_divider.sv | 29 ++
 rtl/count_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types and helpers for the count sequencer controller.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Prescaler register width; a PRESCALE of 1 still needs one bit.
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Prescaler for the count sequencer: tick fires on the last cycle of each
// PRESCALE-cycle period while enabled; clr restarts the period.
module rate_divider
  import count_sequencer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;

  assign tick = en && (prescaler == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr)
      prescaler <= '0;
    else if (en)
      prescaler <= tick ? '0 : prescaler + PW'(1);
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequences a paced up-counter through start/pause/clear/terminal-count phases.
//   state | meaning
//   IDLE  | stopped, count cleared
//   RUN   | counting on prescaler ticks
//   HOLD  | paused, prescaler and count frozen
//   DONE  | terminal count reached, count held
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  seq_state_t       state_q, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [WIDTH-1:0] limit_q, limit_nx;
  logic             done_q, done_nx;
  logic             launch;
  logic             tick;

  assign launch = start && (state_q == IDLE || state_q == DONE);
  assign busy   = (state_q == RUN) || (state_q == HOLD);
  assign count  = count_q;
  assign done   = done_q;
  assign state  = state_q;

  // Advancing while leaving HOLD keeps a pause of N cycles an exact N-cycle delay.
  rate_divider #(.PRESCALE(PRESCALE)) u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .clr   (clear || launch),
    .en    (busy && !pause),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      count_q <= count_nx;
      limit_q <= limit_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    count_nx = count_q;
    limit_nx = limit_q;
    done_nx  = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (launch) begin
      state_nx = RUN;
      count_nx = '0;
      limit_nx = limit;
    end else begin
      case (state_q)
        RUN, HOLD: begin
          if (pause) begin
            state_nx = HOLD;
          end else begin
            state_nx = RUN;
            if (tick) begin
              if (count_q == limit_q) begin
                done_nx = 1'b1;
                if (auto_reload)
                  count_nx = '0;
                else
                  state_nx = DONE;
              end else begin
                count_nx = count_q + WIDTH'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
